// File: rtl/divide_reconstructor.sv
// Sequential shift-add multiply-accumulate: result = A*B + C, one bit of A per RUN cycle.
// Inverse datapath of the restoring divider; same start/valid handshake.
`timescale 1ns/1ps
module divide_reconstructor #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [N-1:0]   C,
  output logic           busy,
  output logic           valid,
  output logic [2*N-1:0] result
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state;
  logic [N:0]      p_hi;   // upper partial product, carry bit on top
  logic [N-1:0]    p_lo;   // multiplier bits, replaced by product bits as they shift in
  logic [N-1:0]    breg;
  logic [N-1:0]    creg;
  logic [CW-1:0]   count;
  logic [N:0]      sum;

  always_comb begin
    sum = p_hi;
    if (p_lo[0]) sum = p_hi + {1'b0, breg};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      p_hi   <= '0;
      p_lo   <= '0;
      breg   <= '0;
      creg   <= '0;
      count  <= '0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p_lo  <= A;
            breg  <= B;
            creg  <= C;
            p_hi  <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p_hi  <= {1'b0, sum[N:1]};
          p_lo  <= {sum[0], p_lo[N-1:1]};
          count <= count + 1'b1;
          if (count == CW'(N-1)) state <= FINISH;
        end
        FINISH: begin
          // (2^N-1)^2 + 2^N-1 < 2^2N, so the add cannot overflow
          result <= {p_hi[N-1:0], p_lo} + {{N{1'b0}}, creg};
          valid  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_reconstructor.sv
// Directed + random bench for divide_reconstructor at N=4 and N=8 with queue scoreboards.
`timescale 1ns/1ps
module tb_divide_reconstructor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start4 = 1'b0;
  logic [3:0]  A4 = '0, B4 = '0, C4 = '0;
  logic        busy4, valid4;
  logic [7:0]  result4;

  logic        start8 = 1'b0;
  logic [7:0]  A8 = '0, B8 = '0, C8 = '0;
  logic        busy8, valid8;
  logic [15:0] result8;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  int n_chk = 0, n_fail = 0, vcount4 = 0, vcount8 = 0;
  int lat, bc, v0;

  divide_reconstructor #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .C(C4),
    .busy(busy4), .valid(valid4), .result(result4));

  divide_reconstructor #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .C(C8),
    .busy(busy8), .valid(valid8), .result(result8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboards: compare on every valid pulse, away from the rising edge
  always @(negedge clk) begin
    if (rst && valid4) begin
      vcount4++;
      chk("busy4_low_in_valid", busy4, 0);
      chk("sb4_pending", q4.size() != 0, 1);
      if (q4.size() != 0) chk("sb4_result", result4, q4.pop_front());
    end
    if (rst && valid8) begin
      vcount8++;
      chk("busy8_low_in_valid", busy8, 0);
      chk("sb8_pending", q8.size() != 0, 1);
      if (q8.size() != 0) chk("sb8_result", result8, q8.pop_front());
    end
  end

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [7:0] e;
    e = a * b + c;
    A4 = a; B4 = b; C4 = c; start4 = 1'b1;
    q4.push_back(e);
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [15:0] e;
    e = a * b + c;
    A8 = a; B8 = b; C8 = c; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1 start8 = 1'b0;
  endtask

  // called #1 after the accepting edge; returns edges until valid and busy cycles seen
  task automatic wait4(output int l, output int b);
    l = 0; b = 0;
    while (!valid4 && l < 40) begin
      if (busy4) b++;
      @(posedge clk); #1 l++;
    end
  endtask

  task automatic wait8(output int l);
    l = 0;
    while (!valid8 && l < 40) begin
      @(posedge clk); #1 l++;
    end
  endtask

  initial begin
    #1;
    chk("rst_busy4", busy4, 0);
    chk("rst_valid4", valid4, 0);
    chk("rst_result4", result4, 0);
    chk("rst_result8", result8, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: basic op and latency
    launch4(4'd2, 4'd3, 4'd1);
    wait4(lat, bc);
    chk("t1_latency", lat, 5);
    chk("t1_busy_cycles", bc, 5);
    @(posedge clk); #1;
    chk("t1_valid_single", valid4, 0);

    // 2: extremes and zero operands
    launch4(4'd15, 4'd15, 4'd15); wait4(lat, bc); chk("t2_lat_max", lat, 5);
    launch4(4'd0, 4'd9, 4'd5);    wait4(lat, bc); chk("t2_lat_a0", lat, 5);
    launch4(4'd7, 4'd0, 4'd0);    wait4(lat, bc); chk("t2_lat_b0", lat, 5);
    @(posedge clk); #1;

    // 3: start held through busy with inputs toggling
    v0 = vcount4;
    A4 = 4'd5; B4 = 4'd6; C4 = 4'd2; start4 = 1'b1;
    q4.push_back(8'd32);
    @(posedge clk); #1;
    lat = 0;
    while (!valid4 && lat < 40) begin
      chk("t3_busy", busy4, 1);
      A4 = 4'($urandom); B4 = 4'($urandom); C4 = 4'($urandom);
      @(posedge clk); #1 lat++;
    end
    chk("t3_latency", lat, 5);
    A4 = 4'd1; B4 = 4'd1; C4 = 4'd0;
    q4.push_back(8'd1);
    @(posedge clk); #1 start4 = 1'b0;
    chk("t3_single_valid", vcount4 - v0, 1);
    chk("t3_second_started", busy4, 1);
    wait4(lat, bc); chk("t3_second_lat", lat, 5);
    @(posedge clk); #1;

    // 4: back-to-back, start in the valid cycle
    launch4(4'd2, 4'd5, 4'd3);
    wait4(lat, bc); chk("t4_first_lat", lat, 5);
    A4 = 4'd3; B4 = 4'd4; C4 = 4'd0; start4 = 1'b1;
    q4.push_back(8'd12);
    @(posedge clk); #1 start4 = 1'b0;
    chk("t4_no_gap", busy4, 1);
    chk("t4_old_result_held", result4, 13);
    wait4(lat, bc); chk("t4_second_lat", lat, 5);
    @(posedge clk); #1;

    // 5: async reset during RUN
    launch4(4'd9, 4'd9, 4'd9);
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("t5_busy", busy4, 0);
    chk("t5_valid", valid4, 0);
    chk("t5_result", result4, 0);
    q4.delete();
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t5_no_valid", valid4, 0);
    end
    launch4(4'd1, 4'd1, 4'd1);
    wait4(lat, bc); chk("t5_fresh_lat", lat, 5);
    @(posedge clk); #1;

    // 6: N=8 max and random sweep
    launch8(8'd255, 8'd255, 8'd255);
    wait8(lat); chk("t6_lat_max", lat, 9);
    @(posedge clk); #1;
    chk("t6_result_hold", result8, 65280);
    for (int i = 0; i < 1000; i++) begin
      launch8(8'($urandom), 8'($urandom), 8'($urandom));
      wait8(lat);
      chk("t6_rand_lat", lat, 9);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb4_drained", q4.size(), 0);
    chk("sb8_drained", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divide_reconstructor.md
Name: divide_reconstructor

Overview:
- Sequential shift-add multiply-accumulate unit. Computes P = A*B + C, i.e. rebuilds the dividend from quotient (A), divisor (B) and remainder (C).
- Acts as the inverse datapath of the team's restoring divider and shares its start/valid handshake style.
- Used in divider self-check paths and wherever a small area-cheap multiplier is needed.
- Takes N+1 clocks per operation after start.

Parameters:
- N, 4, operand width in bits (N >= 2). The result is 2N bits wide.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  N  multiplier (quotient); captured on the accepting edge
- B  input  N  multiplicand (divisor); captured on the accepting edge
- C  input  N  addend (remainder); captured on the accepting edge
- busy  output  1  high while an operation is in flight (state != IDLE)
- valid  output  1  single-cycle completion pulse
- result  output  2N  A*B+C; holds its value until the next completion

Behaviour:
- Reset (rst low, any time, asynchronous): state=IDLE, busy=0, valid=0, result=0, count=0, all internal registers 0. Reset mid-operation aborts the operation; no valid pulse is produced afterwards.
- States: IDLE, RUN, FINISH.
- IDLE:
  - valid=0 except for the cycle immediately after FINISH.
  - On an edge where start=1: capture A into P_lo (N bits), B into Breg, C into Creg. Clear P_hi (N+1 bits, includes carry). Set count=0. Go to RUN.
  - start=0: stay in IDLE; result is unchanged.
- RUN (one iteration per edge):
  - If P_lo[0]=1, sum = P_hi + {0,Breg}, else sum = P_hi.
  - {P_hi,P_lo} <= {sum,P_lo} >> 1 (logical shift, carry bit shifts into the hi part).
  - count <= count+1. After the edge with count==N-1, go to FINISH. RUN therefore lasts exactly N edges.
- FINISH (one edge):
  - result <= P[2N-1:0] + {N'b0,Creg}, truncated to 2N bits. No overflow is possible: max is (2^N-1)^2 + 2^N-1 < 2^2N.
  - valid <= 1, state <= IDLE.
- Timing: if start is accepted at edge E0, RUN edges are E1..EN and FINISH is edge EN+1. valid is high for exactly one cycle after EN+1 and returns low at EN+2.
- busy is high from after E0 through EN+1 and is low while valid is high.
- Start is ignored while busy; A/B/C changes during busy have no effect.
- Back-to-back: start=1 in the cycle valid=1 is accepted, because the state is IDLE. The new result appears N+1 edges later, and the old result stays visible until then.
- A=0 or B=0 gives result=C. All arithmetic is unsigned.
- count is ceil(log2(N)) bits wide minimum, and it must not wrap before N-1.

Test Plan:
1. N=4: A=2, B=3, C=1, one start pulse.
   - Required: valid pulses exactly 5 cycles after the accepting edge, result=7, busy high for 5 cycles.
2. N=4: A=15, B=15, C=15.
   - Required: result=240. Also A=0, B=9, C=5 gives result=5, and A=7, B=0, C=0 gives result=0.
3. Start held high during busy, with A/B/C toggled mid-operation, launched from A=5, B=6, C=2.
   - Required: result=32, a single valid pulse, and a second operation starting only after valid.
4. Back-to-back: start asserted in the valid cycle with A=3, B=4, C=0.
   - Required: first result seen, then 12 five edges later, with no idle gap.
5. rst pulled low at RUN iteration 2.
   - Required: busy=0, valid=0, result=0 immediately (asynchronous). No valid afterwards; a fresh start A=1, B=1, C=1 then gives 2.
6. N=8: A=255, B=255, C=255.
   - Required: result=65280 after 9 edges. Also a random sweep of 1000 vectors comparing against A*B+C.
